// File: rtl/mac_operand_fetch.sv
// mac_operand_fetch: operand sequencer for MAC.L/MAC.W @Rm+,@Rn+.
// It fetches the Rn operand and then the Rm operand over the CPU bus and
// loads each word into the MAC unit: the Rn word goes to MA and the Rm word
// goes to MB. Loading MB arms the MAC execute. At the end it writes the
// post-incremented pointers back to the register file. BUSY stays high
// until the sequence is finished so that the pipeline stalls.
module mac_operand_fetch #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce_r,
    input  logic              res_n,
    input  logic              start,
    input  logic              long_op,
    input  logic              sat,
    input  logic              same_reg,
    input  logic [ADDR_W-1:0] rn_val,
    input  logic [ADDR_W-1:0] rm_val,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_req,
    output logic [3:0]        mem_ba,
    input  logic [31:0]       mem_di,
    input  logic              mem_busy,
    output logic [31:0]       mac_di,
    output logic [ADDR_W-1:0] mac_a,
    output logic [1:0]        mac_sel,
    output logic [3:0]        mac_op,
    output logic              mac_s,
    output logic              mac_we,
    output logic [ADDR_W-1:0] rn_wb,
    output logic [ADDR_W-1:0] rm_wb,
    output logic              wb_en,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_N, S_LD_N, S_RD_M, S_LD_M, S_WB, S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] a1_q, a2_q;
    logic              long_q, sat_q;

    // Operand addresses and alignment, evaluated on the START cycle.
    logic [ADDR_W-1:0] sz, start_a2, rd_addr;
    logic              misaligned, accept;

    assign sz         = long_op ? ADDR_W'(4) : ADDR_W'(2);
    assign start_a2   = same_reg ? rn_val + sz : rm_val;
    assign misaligned = long_op ? ((|rn_val[1:0]) | (|start_a2[1:0]))
                                : (rn_val[0] | start_a2[0]);
    assign rd_addr    = (state == S_RD_M) ? a2_q : a1_q;
    assign accept     = mem_req & ~mem_busy;
    assign mac_s      = sat_q;

    // State register: the soft reset and the clock enable are both synchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ce_r) begin
            // NOTE: sequential state always uses non-blocking assignments, so
            // every flop samples the values from before the edge.
            state <= res_n ? state_nxt : S_IDLE;
        end
    end

    // Next-state logic. START is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = misaligned ? S_ERR : S_RD_N;
            S_RD_N: if (!mem_busy) state_nxt = S_LD_N;
            S_LD_N: state_nxt = S_RD_M;
            S_RD_M: if (!mem_busy) state_nxt = S_LD_M;
            S_LD_M: state_nxt = S_WB;
            S_WB:   state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the addresses and pointer sums at START, and capture
    // the operand word when the bus accepts the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            a2_q   <= '0;
            long_q <= 1'b0;
            sat_q  <= 1'b0;
            rn_wb  <= '0;
            rm_wb  <= '0;
            mac_di <= '0;
            mac_a  <= '0;
        end else if (ce_r) begin
            if (!res_n) begin
                a1_q   <= '0;
                a2_q   <= '0;
                long_q <= 1'b0;
                sat_q  <= 1'b0;
                rn_wb  <= '0;
                rm_wb  <= '0;
                mac_di <= '0;
                mac_a  <= '0;
            end else begin
                if (state == S_IDLE && start) begin
                    a1_q   <= rn_val;
                    a2_q   <= start_a2;
                    long_q <= long_op;
                    sat_q  <= sat;
                    // When Rm and Rn are the same register, the register is
                    // stepped twice, once for each operand.
                    rn_wb  <= same_reg ? rn_val + (sz << 1) : rn_val + sz;
                    rm_wb  <= same_reg ? rn_val + (sz << 1) : rm_val + sz;
                end
                if (accept) begin
                    mac_di <= mem_di;
                    mac_a  <= rd_addr;
                end
            end
        end
    end

    // Outputs decoded from the state. A low soft reset forces the strobes
    // off at once, so the bus request drops before the next edge.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one of
        // them unassigned and no latch is inferred.
        mem_req  = 1'b0;
        mem_a    = '0;
        mem_ba   = 4'b0000;
        mac_we   = 1'b0;
        mac_sel  = 2'b00;
        mac_op   = 4'b0000;
        wb_en    = 1'b0;
        addr_err = 1'b0;
        busy     = (state != S_IDLE);
        if (res_n) begin
            case (state)
                S_RD_N, S_RD_M: begin
                    mem_req = 1'b1;
                    mem_a   = rd_addr;
                    mem_ba  = long_q ? 4'b1111 : (rd_addr[1] ? 4'b0011 : 4'b1100);
                end
                S_LD_N: begin
                    mac_we  = 1'b1;
                    mac_sel = 2'b01;
                    mac_op  = long_q ? 4'b1001 : 4'b1011;
                end
                S_LD_M: begin
                    mac_we  = 1'b1;
                    mac_sel = 2'b10;
                    mac_op  = long_q ? 4'b1001 : 4'b1011;
                end
                S_WB:  wb_en    = 1'b1;
                S_ERR: addr_err = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_fetch.sv
// Directed bench for mac_operand_fetch. Each sequence is driven cycle by
// cycle: outputs are sampled 1 ns after the rising edge, and inputs for the
// same cycle are set after that. Cycle numbers count CE_R cycles, and the
// START cycle is cycle 1.
module tb_mac_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n, ce_r, res_n, start, long_op, sat, same_reg;
    logic [31:0] rn_val, rm_val, mem_a, mem_di, mac_di, mac_a, rn_wb, rm_wb;
    logic        mem_req, mem_busy, mac_s, mac_we, wb_en, busy, addr_err;
    logic [3:0]  mem_ba, mac_op;
    logic [1:0]  mac_sel;

    mac_operand_fetch #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ce_r(ce_r), .res_n(res_n), .start(start),
        .long_op(long_op), .sat(sat), .same_reg(same_reg),
        .rn_val(rn_val), .rm_val(rm_val),
        .mem_a(mem_a), .mem_req(mem_req), .mem_ba(mem_ba), .mem_di(mem_di),
        .mem_busy(mem_busy), .mac_di(mac_di), .mac_a(mac_a), .mac_sel(mac_sel),
        .mac_op(mac_op), .mac_s(mac_s), .mac_we(mac_we), .rn_wb(rn_wb),
        .rm_wb(rm_wb), .wb_en(wb_en), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string tname;

    // Per-sequence log
    int          cyc, n_we, n_req, n_err, wb_cyc, done_cyc, extra_we, extra_wb;
    logic [1:0]  we_sel [2];
    logic [31:0] we_di  [2];
    logic [31:0] we_a   [2];
    logic [3:0]  we_op  [2];
    logic        we_s   [2];
    logic [31:0] rn_l, rm_l;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", tname, tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_ba(input logic lng, input logic [31:0] a);
        return lng ? 4'b1111 : (a[1] ? 4'b0011 : 4'b1100);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one START and follows it to IDLE, then idles three more cycles.
    // wn/wm: wait cycles on each read. start_again: cycle at which START is
    // pulsed again while busy. stall_at: cycle at which CE_R is held low for
    // three clocks. abort: soft reset on the second cycle of the Rm read.
    task automatic do_seq(input logic lng, input logic same, input logic s,
                          input logic [31:0] rn, input logic [31:0] rm,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input int wn, input int wm, input int start_again,
                          input int stall_at, input bit abort);
        logic [31:0] ea1, ea2, ea;
        int  rq0, rq1, stall_left;
        bit  stalled, post_abort, prev_ce;
        ea1 = rn;
        ea2 = same ? rn + (lng ? 32'd4 : 32'd2) : rm;
        rq0 = 0; rq1 = 0; stall_left = 0; stalled = 0; post_abort = 0;
        n_we = 0; n_req = 0; n_err = 0; wb_cyc = 0; done_cyc = 0;
        extra_we = 0; extra_wb = 0; rn_l = '0; rm_l = '0;
        for (int i = 0; i < 2; i++) begin
            we_sel[i] = '0; we_di[i] = '0; we_a[i] = '0; we_op[i] = '0; we_s[i] = 1'b0;
        end
        long_op = lng; same_reg = same; sat = s; rn_val = rn; rm_val = rm;
        start = 1'b1; ce_r = 1'b1; res_n = 1'b1; mem_busy = 1'b0; mem_di = '0;
        cyc = 1;
        for (int k = 0; k < 40; k++) begin
            prev_ce = ce_r;
            tick();
            if (prev_ce) cyc++;
            start = 1'b0; res_n = 1'b1; mem_busy = 1'b0; mem_di = 32'hDEADBEEF;
            if (start_again == cyc && prev_ce) start = 1'b1;
            if (post_abort) begin
                post_abort = 0;
                check("abort_busy", busy, 0);
                check("abort_req", mem_req, 0);
                check("abort_mac_di", mac_di, 0);
                check("abort_rn_wb", rn_wb, 0);
            end
            if (!busy) begin
                done_cyc = cyc;
                break;
            end
            if (stall_at == cyc && !stalled) begin
                stalled = 1;
                stall_left = 3;
            end
            ce_r = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (ce_r) begin
                if (mem_req) begin
                    ea = (n_we == 0) ? ea1 : ea2;
                    check("mem_a", mem_a, ea);
                    check("mem_ba", {28'd0, mem_ba}, {28'd0, exp_ba(lng, ea)});
                    n_req++;
                    if (n_we == 0) begin
                        mem_busy = (rq0 < wn);
                        rq0++;
                        if (!mem_busy) mem_di = d1;
                    end else begin
                        mem_busy = (rq1 < wm);
                        rq1++;
                        if (!mem_busy) mem_di = d2;
                        if (abort && rq1 == 2) begin
                            res_n = 1'b0;
                            mem_busy = 1'b1;
                            post_abort = 1;
                        end
                    end
                end
                if (mac_we) begin
                    if (n_we < 2) begin
                        we_sel[n_we] = mac_sel; we_di[n_we] = mac_di;
                        we_a[n_we] = mac_a; we_op[n_we] = mac_op; we_s[n_we] = mac_s;
                    end
                    n_we++;
                end
                if (wb_en) begin
                    wb_cyc = cyc;
                    rn_l = rn_wb;
                    rm_l = rm_wb;
                end
                if (addr_err) n_err++;
            end
        end
        check("done_busy", busy, 0);
        ce_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (mac_we) extra_we++;
            if (wb_en) extra_wb++;
            if (mem_req) n_req++;
        end
        check("idle_after", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; ce_r = 1'b1; res_n = 1'b1; start = 1'b0; long_op = 1'b0;
        sat = 1'b0; same_reg = 1'b0; rn_val = '0; rm_val = '0;
        mem_di = '0; mem_busy = 1'b0;
        repeat (3) tick();

        tname = "reset";
        check("busy", busy, 0);
        check("mem_req", mem_req, 0);
        check("mem_a", mem_a, 0);
        check("mac_di", mac_di, 0);
        check("mac_a", mac_a, 0);
        check("rn_wb", rn_wb, 0);
        check("strobes", {mac_we, wb_en, addr_err, mac_sel, mac_op}, 0);
        rst_n = 1'b1;
        tick();
        check("busy_rel", busy, 0);

        // 1) MAC.L, no waits
        tname = "long";
        do_seq(1, 0, 0, 32'h100, 32'h200, 32'h3, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
        check("n_we", n_we, 2);
        check("sel0", we_sel[0], 2'b01);
        check("di0", we_di[0], 32'h3);
        check("a0", we_a[0], 32'h100);
        check("op0", we_op[0], 4'b1001);
        check("sel1", we_sel[1], 2'b10);
        check("di1", we_di[1], 32'hFFFFFFFE);
        check("a1", we_a[1], 32'h200);
        check("s0", we_s[0], 0);
        check("rn_wb", rn_l, 32'h104);
        check("rm_wb", rm_l, 32'h204);
        check("wb_cyc", wb_cyc, 6);
        check("done_cyc", done_cyc, 7);
        check("extra", extra_we + extra_wb, 0);

        // 2) MAC.W with three wait cycles on the Rn read
        tname = "word_wait";
        do_seq(0, 0, 0, 32'h102, 32'h300, 32'h0000ABCD, 32'h12340000, 3, 0, 0, 0, 0);
        check("n_we", n_we, 2);
        check("a0", we_a[0], 32'h102);
        check("di0", we_di[0], 32'h0000ABCD);
        check("op0", we_op[0], 4'b1011);
        check("a1", we_a[1], 32'h300);
        check("di1", we_di[1], 32'h12340000);
        check("rn_wb", rn_l, 32'h104);
        check("rm_wb", rm_l, 32'h302);
        check("wb_cyc", wb_cyc, 9);
        check("n_req", n_req, 5);

        // 3) same register, MAC.L, S set, CE_R held low for 3 clocks in LD_N
        tname = "same_reg";
        do_seq(1, 1, 1, 32'h400, 32'h999, 32'h11111111, 32'h22222222, 0, 0, 0, 3, 0);
        check("n_we", n_we, 2);
        check("a0", we_a[0], 32'h400);
        check("a1", we_a[1], 32'h404);
        check("di1", we_di[1], 32'h22222222);
        check("s1", we_s[1], 1);
        check("rn_wb", rn_l, 32'h408);
        check("rm_wb", rm_l, 32'h408);
        check("wb_cyc", wb_cyc, 6);

        // 4) misaligned Rm operand on MAC.L
        tname = "misalign_l";
        do_seq(1, 0, 0, 32'h100, 32'h202, 32'h1, 32'h2, 0, 0, 0, 0, 0);
        check("n_err", n_err, 1);
        check("n_we", n_we + extra_we, 0);
        check("n_req", n_req, 0);
        check("wb", wb_cyc + extra_wb, 0);
        check("done_cyc", done_cyc, 3);

        // 4b) odd Rn address on MAC.W
        tname = "misalign_w";
        do_seq(0, 0, 0, 32'h101, 32'h200, 32'h1, 32'h2, 0, 0, 0, 0, 0);
        check("n_err", n_err, 1);
        check("n_req", n_req, 0);

        // 4c) same register, MAC.W: Rn=0x102, so A2=0x104 is aligned
        tname = "same_w";
        do_seq(0, 1, 0, 32'h102, 32'h0, 32'h5, 32'h6, 0, 0, 0, 0, 0);
        check("n_err", n_err, 0);
        check("a1", we_a[1], 32'h104);
        check("rm_wb", rm_l, 32'h106);

        // 5) soft reset while the Rm read is waiting
        tname = "abort";
        do_seq(1, 0, 0, 32'h100, 32'h200, 32'hAA, 32'hBB, 0, 5, 0, 0, 1);
        check("n_we", n_we + extra_we, 1);
        check("wb", wb_cyc + extra_wb, 0);
        check("done_cyc", done_cyc, 6);

        // 6) pointer wrap, and a second START while busy
        tname = "wrap";
        do_seq(1, 0, 0, 32'hFFFFFFFC, 32'h200, 32'h7, 32'h8, 0, 0, 3, 0, 0);
        check("n_we", n_we + extra_we, 2);
        check("rn_wb", rn_l, 32'h0);
        check("rm_wb", rm_l, 32'h204);
        check("a0", we_a[0], 32'hFFFFFFFC);
        check("n_req", n_req, 2);
        check("wb_cyc", wb_cyc, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
